// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding and data width.
package uart_tx_feeder_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    FEED_IDLE      = 2'd0,
    FEED_LAUNCH    = 2'd1,
    FEED_WAIT_BUSY = 2'd2,
    FEED_WAIT_DONE = 2'd3
  } feed_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a synchronous flush.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes in a FIFO and launches them one at a time into the UART,
// pacing on its busy flag and dropping a byte whose launch is never acknowledged.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 4,
  parameter int unsigned CW           = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [CW-1:0]     count,
  output logic              idle,
  output logic              lost
);

  localparam int unsigned     TW       = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(BUSY_TIMEOUT - 1);

  feed_state_e       state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CW-1:0]     fifo_count;
  logic              push, pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FEED_IDLE;
      tmo_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
    end
  end

  // A flush suppresses a pop decided this cycle but never disturbs a byte already launched.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    pop       = (state_q == FEED_IDLE) && (fifo_count != '0) && !flush;
    case (state_q)
      FEED_IDLE: begin
        if (pop) begin
          state_d   = FEED_LAUNCH;
          tx_data_d = fifo_rd_data;
        end
      end
      FEED_LAUNCH: begin
        state_d = FEED_WAIT_BUSY;
        tmo_d   = TMO_LOAD;
      end
      FEED_WAIT_BUSY: begin
        if (tx_busy)            state_d = FEED_WAIT_DONE;
        else if (tmo_q == '0)   state_d = FEED_IDLE;
        else                    tmo_d   = tmo_q - TW'(1);
      end
      FEED_WAIT_DONE: begin
        if (!tx_busy) state_d = FEED_IDLE;
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (fifo_count != CW'(DEPTH)) && !flush;
    push     = in_valid && in_ready;
    tx_start = (state_q == FEED_LAUNCH);
    lost     = (state_q == FEED_WAIT_BUSY) && !tx_busy && (tmo_q == '0);
    idle     = (state_q == FEED_IDLE) && (fifo_count == '0);
    tx_data  = tx_data_q;
    count    = fifo_count;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a simple UART busy model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] count;
  logic       idle;
  logic       lost;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  logic        uart_en;
  int unsigned busy_len;
  int unsigned busy_cnt = 0;

  // Monitor records
  int unsigned cyc = 0;
  logic        prev_start = 1'b0;
  int unsigned dbl_start = 0;
  int unsigned overlap   = 0;
  logic [7:0]  launched[$];
  int unsigned start_cyc[$];
  int unsigned lost_cyc[$];

  int unsigned base;
  int unsigned lbase;
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH        (16),
    .BUSY_TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .count    (count),
    .idle     (idle),
    .lost     (lost)
  );

  assign tx_busy = uart_en && (busy_cnt != 0);

  always @(posedge clk) begin
    if (uart_en && tx_start && busy_cnt == 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)                   busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_start <= tx_start;
    if (tx_start) begin
      launched.push_back(tx_data);
      start_cyc.push_back(cyc);
      if (prev_start) dbl_start <= dbl_start + 1;
      if (tx_busy)    overlap   <= overlap + 1;
    end
    if (lost) lost_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_tx_data"},  32'(tx_data),  32'h00);
    check_eq({tag, "_lost"},     32'(lost),     32'd0);
    check_eq({tag, "_idle"},     32'(idle),     32'd1);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_count"},    32'(count),    32'd0);
  endtask

  task automatic wait_idle(input string tag, input int unsigned bound);
    int unsigned i = 0;
    while (!(idle && !tx_busy) && i < bound) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_idle_reached"}, 32'(idle && !tx_busy), 32'd1);
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    uart_en  = 1'b1;
    busy_len = 40;

    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single byte into an empty FIFO
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1 check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t1_count_after_accept", 32'(count), 32'd1);
    check_eq("t1_no_start_yet", 32'(tx_start), 32'd0);
    @(negedge clk);
    check_eq("t1_tx_start", 32'(tx_start), 32'd1);
    check_eq("t1_tx_data", 32'(tx_data), 32'hA5);
    check_eq("t1_count_after_pop", 32'(count), 32'd0);
    @(negedge clk);
    check_eq("t1_start_single", 32'(tx_start), 32'd0);
    check_eq("t1_busy_seen", 32'(tx_busy), 32'd1);
    check_eq("t1_data_held", 32'(tx_data), 32'hA5);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    check_eq("t1_busy_fell", 32'(tx_busy), 32'd0);
    check_eq("t1_idle_during_wait_done", 32'(idle), 32'd0);
    @(negedge clk);
    check_eq("t1_idle_back", 32'(idle), 32'd1);
    check_eq("t1_launch_count", 32'(launched.size()), 32'd1);

    // Burst to full while the UART holds a long dummy transmission
    busy_len = 100;
    base     = launched.size();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("t3_push_pop_same_cycle_count", 32'(count), 32'd1);
      in_data = 8'(i);
    end
    @(negedge clk);
    in_data = 8'h10;
    #1;
    check_eq("t3_full_count", 32'(count), 32'd16);
    check_eq("t3_full_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("t3_held_off_count", 32'(count), 32'd16);
    check_eq("t3_held_off_in_ready", 32'(in_ready), 32'd0);
    busy_len = 20;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    check_eq("t3_room_after_pop", 32'(in_ready), 32'd1);
    check_eq("t3_count_after_pop", 32'(count), 32'd15);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t3_refill_count", 32'(count), 32'd16);
    wait_idle("t3", 1000);
    check_eq("t3_launches", 32'(launched.size() - base), 32'd18);
    if (launched.size() >= base + 18) begin
      check_eq("t3_order_dummy", 32'(launched[base]), 32'hEE);
      for (int i = 1; i < 18; i++) begin
        exp_b = 8'(i - 1);
        check_eq($sformatf("t3_order_%0d", i), 32'(launched[base + i]), 32'(exp_b));
      end
    end

    // UART never acknowledges: each launch times out
    uart_en  = 1'b0;
    base     = launched.size();
    lbase    = lost_cyc.size();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_data  = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && lost_cyc.size() < lbase + 2; i++) @(negedge clk);
    check_eq("t5_lost_pulses", 32'(lost_cyc.size() - lbase), 32'd2);
    check_eq("t5_launches", 32'(launched.size() - base), 32'd2);
    if (launched.size() >= base + 2 && lost_cyc.size() >= lbase + 1) begin
      check_eq("t5_first_byte", 32'(launched[base]), 32'h3C);
      check_eq("t5_next_byte", 32'(launched[base + 1]), 32'h5A);
      check_eq("t5_lost_delay", lost_cyc[lbase] - start_cyc[base], 32'd4);
      check_eq("t5_relaunch_delay", start_cyc[base + 1] - lost_cyc[lbase], 32'd2);
    end
    wait_idle("t5", 40);
    uart_en = 1'b1;

    // Flush with 5 queued and one in flight
    busy_len = 30;
    base     = launched.size();
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    check_eq("t6_queued", 32'(count), 32'd5);
    check_eq("t6_in_flight", 32'(tx_busy), 32'd1);
    flush   = 1'b1;
    in_data = 8'h99;
    #1 check_eq("t6_flush_blocks_push", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_count_cleared", 32'(count), 32'd0);
    check_eq("t6_still_busy", 32'(tx_busy), 32'd1);
    wait_idle("t6", 100);
    repeat (10) @(negedge clk);
    check_eq("t6_launches", 32'(launched.size() - base), 32'd1);
    if (launched.size() > base) check_eq("t6_inflight_byte", 32'(launched[base]), 32'h60);

    // Asynchronous reset mid-WAIT_DONE with 3 queued
    base     = launched.size();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h70 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("t7_queued", 32'(count), 32'd3);
    check_eq("t7_wait_done_idle", 32'(idle), 32'd0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("t7_async");
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("t7_no_launch_after_release", 32'(launched.size() - base), 32'd1);
    check_eq("t7_idle_after_release", 32'(idle), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && launched.size() < base + 2; i++) @(negedge clk);
    check_eq("t7_new_launch", 32'(launched.size() - base), 32'd2);
    if (launched.size() >= base + 2) check_eq("t7_new_byte", 32'(launched[base + 1]), 32'h81);
    wait_idle("t7", 100);

    check_eq("no_back_to_back_start", dbl_start, 32'd0);
    check_eq("no_start_while_busy", overlap, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
